// File: rtl/spi_axis_slave.sv
// SPI mode-3 slave: oversampled SPI pins in, received bytes out on AXIS master,
// MISO bytes taken from an AXIS slave through a single-entry holding register.
module spi_axis_slave #(
    parameter bit         MSB_FIRST   = 1'b1,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    input  logic       spi_csn,
    input  logic       spi_clk,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic       frame_active,
    output logic [7:0] rx_overrun_cnt,
    output logic [7:0] tx_underrun_cnt
);

    localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

    // ------------------------------------------------------------------
    // Pin synchronizers and registered edge pulses
    // ------------------------------------------------------------------
    logic [NS-1:0] clk_sync_q, csn_sync_q, mosi_sync_q;
    logic          clk_prev_q, csn_prev_q, mosi_smp_q;
    logic          clk_rise_q, clk_fall_q, cs_rise_q, cs_fall_q;
    logic [NS:0]   settle_q;
    logic          armed_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q  <= '1;
            csn_sync_q  <= '1;
            mosi_sync_q <= '0;
            clk_prev_q  <= 1'b1;
            csn_prev_q  <= 1'b1;
            mosi_smp_q  <= 1'b0;
            clk_rise_q  <= 1'b0;
            clk_fall_q  <= 1'b0;
            cs_rise_q   <= 1'b0;
            cs_fall_q   <= 1'b0;
            settle_q    <= '0;
            armed_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking here so every stage samples the previous cycle's value.
            clk_sync_q  <= {clk_sync_q[NS-2:0], spi_clk};
            csn_sync_q  <= {csn_sync_q[NS-2:0], spi_csn};
            mosi_sync_q <= {mosi_sync_q[NS-2:0], spi_mosi};
            clk_prev_q  <= clk_sync_q[NS-1];
            csn_prev_q  <= csn_sync_q[NS-1];
            mosi_smp_q  <= mosi_sync_q[NS-1];
            clk_rise_q  <=  clk_sync_q[NS-1] & ~clk_prev_q;
            clk_fall_q  <= ~clk_sync_q[NS-1] &  clk_prev_q;
            cs_rise_q   <=  csn_sync_q[NS-1] & ~csn_prev_q;
            cs_fall_q   <= ~csn_sync_q[NS-1] &  csn_prev_q;
            settle_q    <= {settle_q[NS-1:0], 1'b1};
            // A frame may only start after CS has really been seen high, so a
            // reset in the middle of a frame ignores the rest of that frame.
            if (settle_q[NS] && csn_prev_q)
                armed_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM, shift registers, TX holding register, AXIS output
    // ------------------------------------------------------------------
    state_t     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] hold_data_q, hold_data_d;
    logic       hold_valid_q, hold_valid_d;
    logic [7:0] m_tdata_q, m_tdata_d;
    logic       m_tvalid_q, m_tvalid_d;
    logic       miso_q, miso_d;
    logic       oe_q, oe_d;
    logic [7:0] rx_ovr_q, rx_ovr_d;
    logic [7:0] tx_unr_q, tx_unr_d;

    logic       load_tx;
    logic       m_free;
    logic [7:0] rx_next, tx_next, tx_fill;

    function automatic logic first_bit(input logic [7:0] b);
        return MSB_FIRST ? b[7] : b[0];
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        rx_shift_d   = rx_shift_q;
        tx_shift_d   = tx_shift_q;
        hold_data_d  = hold_data_q;
        hold_valid_d = hold_valid_q;
        m_tdata_d    = m_tdata_q;
        m_tvalid_d   = m_tvalid_q;
        miso_d       = miso_q;
        oe_d         = oe_q;
        rx_ovr_d     = rx_ovr_q;
        tx_unr_d     = tx_unr_q;
        load_tx      = 1'b0;

        rx_next = MSB_FIRST ? {rx_shift_q[6:0], mosi_smp_q} : {mosi_smp_q, rx_shift_q[7:1]};
        tx_next = MSB_FIRST ? {tx_shift_q[6:0], 1'b0}       : {1'b0, tx_shift_q[7:1]};
        tx_fill = hold_valid_q ? hold_data_q : IDLE_BYTE;
        m_free  = !m_tvalid_q || m_axis_tready;

        if (m_tvalid_q && m_axis_tready)
            m_tvalid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                oe_d = 1'b0;
                if (cs_fall_q && armed_q) begin
                    load_tx    = 1'b1;
                    bit_cnt_d  = 4'd0;
                    rx_shift_d = 8'h00;
                    oe_d       = 1'b1;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cs_rise_q) begin
                    state_d = ST_IDLE;
                    oe_d    = 1'b0;
                end else if (clk_rise_q && bit_cnt_q < 4'd8) begin
                    rx_shift_d = rx_next;
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        if (m_free) begin
                            m_tdata_d  = rx_next;
                            m_tvalid_d = 1'b1;
                        end else begin
                            rx_ovr_d = sat_inc(rx_ovr_q);
                        end
                    end
                end else if (clk_fall_q) begin
                    // The first fall of a byte is the master's setup edge; the
                    // first bit is already on MISO, so it is held, not shifted.
                    if (bit_cnt_q == 4'd8) begin
                        load_tx   = 1'b1;
                        bit_cnt_d = 4'd0;
                    end else if (bit_cnt_q != 4'd0) begin
                        tx_shift_d = tx_next;
                        miso_d     = first_bit(tx_next);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load_tx) begin
            tx_shift_d = tx_fill;
            miso_d     = first_bit(tx_fill);
            if (hold_valid_q)
                hold_valid_d = 1'b0;
            else
                tx_unr_d = sat_inc(tx_unr_q);
        end

        // A handshake only happens while the holder is empty, so it always wins.
        if (s_axis_tvalid && !hold_valid_q) begin
            hold_data_d  = s_axis_tdata;
            hold_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 4'd0;
            rx_shift_q   <= 8'h00;
            tx_shift_q   <= 8'h00;
            hold_data_q  <= 8'h00;
            hold_valid_q <= 1'b0;
            m_tdata_q    <= 8'h00;
            m_tvalid_q   <= 1'b0;
            miso_q       <= 1'b0;
            oe_q         <= 1'b0;
            rx_ovr_q     <= 8'h00;
            tx_unr_q     <= 8'h00;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_shift_q   <= rx_shift_d;
            tx_shift_q   <= tx_shift_d;
            hold_data_q  <= hold_data_d;
            hold_valid_q <= hold_valid_d;
            m_tdata_q    <= m_tdata_d;
            m_tvalid_q   <= m_tvalid_d;
            miso_q       <= miso_d;
            oe_q         <= oe_d;
            rx_ovr_q     <= rx_ovr_d;
            tx_unr_q     <= tx_unr_d;
        end
    end

    assign s_axis_tready   = !hold_valid_q;
    assign m_axis_tdata    = m_tdata_q;
    assign m_axis_tvalid   = m_tvalid_q;
    assign spi_miso        = miso_q;
    assign spi_miso_oe     = oe_q;
    assign frame_active    = !csn_prev_q;
    assign rx_overrun_cnt  = rx_ovr_q;
    assign tx_underrun_cnt = tx_unr_q;

endmodule

// File: tb/tb_spi_axis_slave.sv
// Directed bench for spi_axis_slave: the bench plays the SPI master at clk/8
// against an MSB-first instance and an LSB-first instance.
module tb_spi_axis_slave;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic [7:0] s_tdata = 8'h00;
    logic       s_tvalid = 1'b0;
    logic       s_tready;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tready = 1'b1;
    logic       csn = 1'b1;
    logic       csn_l = 1'b1;
    logic       spi_clk = 1'b1;
    logic       mosi = 1'b0;
    logic       miso, miso_oe, frame_act;
    logic [7:0] rx_ovr, tx_unr;

    logic [7:0] s_tdata_l = 8'h00;
    logic       s_tvalid_l = 1'b0;
    logic       s_tready_l;
    logic [7:0] m_tdata_l;
    logic       m_tvalid_l;
    logic       m_tready_l = 1'b1;
    logic       miso_l, miso_oe_l, frame_act_l;
    logic [7:0] rx_ovr_l, tx_unr_l;

    spi_axis_slave #(.MSB_FIRST(1'b1), .SYNC_STAGES(2), .IDLE_BYTE(8'h00)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .spi_csn(csn), .spi_clk(spi_clk), .spi_mosi(mosi),
        .spi_miso(miso), .spi_miso_oe(miso_oe), .frame_active(frame_act),
        .rx_overrun_cnt(rx_ovr), .tx_underrun_cnt(tx_unr)
    );

    spi_axis_slave #(.MSB_FIRST(1'b0), .SYNC_STAGES(2), .IDLE_BYTE(8'h01)) dut_lsb (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata_l), .s_axis_tvalid(s_tvalid_l), .s_axis_tready(s_tready_l),
        .m_axis_tdata(m_tdata_l), .m_axis_tvalid(m_tvalid_l), .m_axis_tready(m_tready_l),
        .spi_csn(csn_l), .spi_clk(spi_clk), .spi_mosi(mosi),
        .spi_miso(miso_l), .spi_miso_oe(miso_oe_l), .frame_active(frame_act_l),
        .rx_overrun_cnt(rx_ovr_l), .tx_underrun_cnt(tx_unr_l)
    );

    // Beat monitors: log every completed m_axis handshake.
    int         beat_cnt = 0;
    logic [7:0] beat_log [64];
    int         lsb_cnt = 0;
    logic [7:0] lsb_last = 8'h00;

    always @(posedge clk) begin
        if (!rst && m_tvalid && m_tready) begin
            beat_log[beat_cnt % 64] <= m_tdata;
            beat_cnt <= beat_cnt + 1;
        end
        if (!rst && m_tvalid_l && m_tready_l) begin
            lsb_last <= m_tdata_l;
            lsb_cnt  <= lsb_cnt + 1;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Master side of one byte (or the first nbits of it); called on a negedge.
    task automatic spi_bits(input logic [7:0] b, input int nbits, input bit msb,
                            input bit use_lsb, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            int idx;
            idx = msb ? 7 - i : i;
            spi_clk = 1'b0;
            mosi    = b[idx];
            repeat (4) @(negedge clk);
            rx[idx] = use_lsb ? miso_l : miso;
            spi_clk = 1'b1;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic cs_low(input bit use_lsb);
        @(negedge clk);
        if (use_lsb) csn_l = 1'b0;
        else         csn   = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (4) @(negedge clk);
        csn   = 1'b1;
        csn_l = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic s_push(input logic [7:0] d);
        int n;
        n = 0;
        while (!s_tready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("push_ready", s_tready, 1);
        s_tdata  = d;
        s_tvalid = 1'b1;
        @(negedge clk);
        s_tvalid = 1'b0;
    endtask

    logic [7:0] rx0, rx1, rx2;

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_s_tready", s_tready, 1);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tdata", m_tdata, 8'h00);
        check("rst_miso", miso, 0);
        check("rst_miso_oe", miso_oe, 0);
        check("rst_frame_active", frame_act, 0);
        check("rst_rx_ovr", rx_ovr, 0);
        check("rst_tx_unr", tx_unr, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Single byte A5, no TX data
        cs_low(1'b0);
        check("a5_oe_in_frame", miso_oe, 1);
        check("a5_frame_active", frame_act, 1);
        spi_bits(8'hA5, 8, 1'b1, 1'b0, rx0);
        check("a5_miso_idle", rx0, 8'h00);
        cs_high();
        check("a5_beat_cnt", beat_cnt, 1);
        check("a5_beat_data", beat_log[0], 8'hA5);
        check("a5_rx_ovr", rx_ovr, 0);
        check("a5_tx_unr", tx_unr, 1);
        check("a5_oe_after", miso_oe, 0);
        check("a5_frame_inactive", frame_act, 0);

        // Multi-byte exchange with the holding register
        s_push(8'h3C);
        check("hold_full", s_tready, 0);
        cs_low(1'b0);
        check("tready_after_load1", s_tready, 1);
        s_push(8'hC3);
        check("hold_full2", s_tready, 0);
        spi_bits(8'h11, 8, 1'b1, 1'b0, rx0);
        spi_bits(8'h22, 8, 1'b1, 1'b0, rx1);
        cs_high();
        check("multi_miso0", rx0, 8'h3C);
        check("multi_miso1", rx1, 8'hC3);
        check("multi_beat_cnt", beat_cnt, 3);
        check("multi_beat1", beat_log[1], 8'h11);
        check("multi_beat2", beat_log[2], 8'h22);
        check("tready_after_load2", s_tready, 1);
        check("multi_tx_unr", tx_unr, 1);

        // TX underrun, 3-byte frame
        cs_low(1'b0);
        spi_bits(8'h5A, 8, 1'b1, 1'b0, rx0);
        spi_bits(8'h5B, 8, 1'b1, 1'b0, rx1);
        spi_bits(8'h5C, 8, 1'b1, 1'b0, rx2);
        cs_high();
        check("unr_miso0", rx0, 8'h00);
        check("unr_miso1", rx1, 8'h00);
        check("unr_miso2", rx2, 8'h00);
        check("unr_tx_unr", tx_unr, 4);
        check("unr_beat_cnt", beat_cnt, 6);
        check("unr_beat5", beat_log[5], 8'h5C);

        // RX overrun with downstream stalled
        m_tready = 1'b0;
        cs_low(1'b0);
        spi_bits(8'h01, 8, 1'b1, 1'b0, rx0);
        spi_bits(8'h02, 8, 1'b1, 1'b0, rx0);
        spi_bits(8'h03, 8, 1'b1, 1'b0, rx0);
        cs_high();
        check("ovr_tvalid", m_tvalid, 1);
        check("ovr_tdata", m_tdata, 8'h01);
        check("ovr_cnt", rx_ovr, 2);
        check("ovr_no_beat", beat_cnt, 6);
        m_tready = 1'b1;
        repeat (4) @(negedge clk);
        check("ovr_one_beat", beat_cnt, 7);
        check("ovr_beat_data", beat_log[6], 8'h01);
        check("ovr_tvalid_clr", m_tvalid, 0);
        check("ovr_tx_unr", tx_unr, 7);

        // Partial byte, then a clean full byte
        cs_low(1'b0);
        spi_bits(8'hFF, 5, 1'b1, 1'b0, rx0);
        cs_high();
        check("part_no_beat", beat_cnt, 7);
        check("part_oe", miso_oe, 0);
        check("part_tvalid", m_tvalid, 0);
        cs_low(1'b0);
        spi_bits(8'h96, 8, 1'b1, 1'b0, rx0);
        cs_high();
        check("part_next_cnt", beat_cnt, 8);
        check("part_next_data", beat_log[7], 8'h96);
        check("part_rx_ovr", rx_ovr, 2);
        check("part_tx_unr", tx_unr, 9);

        // LSB-first instance
        cs_low(1'b1);
        spi_bits(8'h80, 8, 1'b0, 1'b1, rx0);
        cs_high();
        check("lsb_beat_cnt", lsb_cnt, 1);
        check("lsb_beat_data", lsb_last, 8'h80);
        check("lsb_miso", rx0, 8'h01);
        check("lsb_main_quiet", beat_cnt, 8);

        // Reset in the middle of a byte
        cs_low(1'b0);
        spi_bits(8'hF0, 4, 1'b1, 1'b0, rx0);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_s_tready", s_tready, 1);
        check("mrst_m_tvalid", m_tvalid, 0);
        check("mrst_m_tdata", m_tdata, 8'h00);
        check("mrst_miso", miso, 0);
        check("mrst_oe", miso_oe, 0);
        check("mrst_frame_active", frame_act, 0);
        check("mrst_rx_ovr", rx_ovr, 0);
        check("mrst_tx_unr", tx_unr, 0);
        rst = 1'b0;
        spi_bits(8'h0F, 4, 1'b0, 1'b0, rx0);
        spi_bits(8'h77, 8, 1'b1, 1'b0, rx0);
        cs_high();
        check("mrst_no_beat", beat_cnt, 8);
        check("mrst_oe_idle", miso_oe, 0);
        check("mrst_tx_unr_idle", tx_unr, 0);
        cs_low(1'b0);
        spi_bits(8'h5A, 8, 1'b1, 1'b0, rx0);
        cs_high();
        check("mrst_fresh_cnt", beat_cnt, 9);
        check("mrst_fresh_data", beat_log[8], 8'h5A);
        check("mrst_fresh_tx_unr", tx_unr, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
